// File: rtl/shifter_iter.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_iter
//  Description : Multi-cycle shift/rotate unit with valid/ready handshakes.
//                Moves at most STEP bit positions per clock until the
//                requested amount has been applied.
//                Optional build macro SHIFTER_STATUS_EN adds the out_zero
//                and out_cout status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter_iter #(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_STATUS_EN
    ,
    output logic             out_zero,
    output logic             out_cout
`endif
);

    localparam logic [1:0] c_op_rol = 2'b00;
    localparam logic [1:0] c_op_sll = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_data;
    logic [1:0]          r_op;
    logic [AMT_W-1:0]    r_rem;
    logic                r_sign;
    logic                r_out_valid;

    logic                w_accept;
    logic [AMT_W-1:0]    w_k;
    logic                w_fill;
    logic [2*WIDTH-1:0]  w_lext;
    logic [2*WIDTH:0]    w_rext;
    logic [WIDTH-1:0]    w_next;
    logic                w_unused_bits;

    // A new request is taken from IDLE, or from DONE when the result leaves
    // in the same cycle (back-to-back issue).
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;

    // Step size for this cycle: the smaller of STEP and the remaining amount.
    // When STEP >= WIDTH the remaining count can never exceed it.
    always_comb begin
        w_k = r_rem;
        if ({{(32-AMT_W){1'b0}}, r_rem} > $unsigned(STEP))
            w_k = AMT_W'(STEP);
    end

    // Left shifts use a double-width window: the upper half holds the bits
    // that fell off the top (re-inserted for rotate). Right shifts use a
    // window with the fill above and one guard bit below that catches the
    // last bit shifted out.
    assign w_fill = (r_op == c_op_sra) && r_sign;
    assign w_lext = {{WIDTH{1'b0}}, r_data} << w_k;
    assign w_rext = {{WIDTH{w_fill}}, r_data, 1'b0} >> w_k;

    // Next data value for one shift step.
    always_comb begin
        w_next = w_rext[WIDTH:1];
        case (r_op)
            c_op_rol: w_next = w_lext[WIDTH-1:0] | w_lext[2*WIDTH-1:WIDTH];
            c_op_sll: w_next = w_lext[WIDTH-1:0];
            default:  w_next = w_rext[WIDTH:1];
        endcase
    end

    // Fill bits above the right-shift result are never observed.
    assign w_unused_bits = ^{w_rext[2*WIDTH:WIDTH+1], w_rext[0]};

    // Control FSM: load on accept, step until the count is exhausted, then
    // present the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_op        <= '0;
            r_rem       <= '0;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_op    <= in_op;
                        r_rem   <= in_amt;
                        r_sign  <= in_data[WIDTH-1];
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_rem == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_data <= w_next;
                        r_rem  <= r_rem - w_k;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_data  <= in_data;
                            r_op    <= in_op;
                            r_rem   <= in_amt;
                            r_sign  <= in_data[WIDTH-1];
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFTER_STATUS_EN
    logic r_zero;
    logic r_cout;
    logic w_step_cout;

    // Last bit leaving the word: top side for left ops, guard bit for right.
    assign w_step_cout = r_op[1] ? w_rext[0] : w_lext[WIDTH];
    assign out_zero    = r_zero;
    assign out_cout    = r_cout;

    // Status flags: cleared on accept, carry tracked per step, zero taken
    // from the final value as the result is published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_zero <= 1'b0;
            r_cout <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            if (r_rem == '0)
                r_zero <= (r_data == '0);
            else
                r_cout <= w_step_cout;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shifter_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shifter_iter
//  Description : Self-checking bench for shifter_iter (WIDTH=16, STEP=8 and
//                a STEP=1 instance). Status outputs are checked when
//                SHIFTER_STATUS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [1:0]  in_op;
    logic [3:0]  in_amt;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_in_op;
    logic [3:0]  b_in_amt;
`ifdef SHIFTER_STATUS_EN
    logic        out_zero, out_cout, b_out_zero, b_out_cout;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] data;
        logic        zero;
        logic        cout;
        int          due;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shifter_iter #(.WIDTH(16), .STEP(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_op(in_op), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SHIFTER_STATUS_EN
        , .out_zero(out_zero), .out_cout(out_cout)
`endif
    );

    shifter_iter #(.WIDTH(16), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_op(b_in_op), .in_amt(b_in_amt),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef SHIFTER_STATUS_EN
        , .out_zero(b_out_zero), .out_cout(b_out_cout)
`endif
    );

    // Bit-serial reference: {zero, cout, result}
    function automatic logic [17:0] model(input logic [1:0] op, input logic [15:0] d,
                                          input int amt);
        logic [15:0] r;
        logic        c;
        logic        s;
        r = d; c = 1'b0; s = d[15];
        for (int i = 0; i < amt; i++) begin
            case (op)
                2'b00: begin c = r[15]; r = {r[14:0], r[15]}; end
                2'b01: begin c = r[15]; r = {r[14:0], 1'b0}; end
                2'b10: begin c = r[0];  r = {s, r[15:1]};    end
                default: begin c = r[0]; r = {1'b0, r[15:1]}; end
            endcase
        end
        return {(r == 16'h0), c, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] op, input logic [15:0] d, input int amt,
                            input int t, input int step);
        exp_t        e;
        logic [17:0] m;
        m      = model(op, d, amt);
        e.data = m[15:0];
        e.cout = m[16];
        e.zero = m[17];
        e.due  = t + 1 + (amt + step - 1) / step;
        sb.push_back(e);
    endtask

    // Offer a request and wait (bounded) until it is taken.
    task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] amt);
        int n;
        in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt;
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        check("send_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        push_exp(op, d, int'(amt), cyc, 8);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_op    = 2'($urandom);
        in_amt   = 4'($urandom);
    endtask

    // Wait (bounded) for a result and compare against the scoreboard head.
    task automatic recv(input string tag);
        int   n;
        exp_t e;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check({tag, "_valid"}, out_valid, 1'b1);
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, out_data, e.data);
            check({tag, "_cycle"}, cyc, e.due);
`ifdef SHIFTER_STATUS_EN
            check({tag, "_zero"}, out_zero, e.zero);
            check({tag, "_cout"}, out_cout, e.cout);
`endif
            @(posedge clk); #1;
            check({tag, "_drop"}, out_valid, 1'b0);
        end
    endtask

    initial begin
        int          n;
        int          t;
        exp_t        e;
        logic [15:0] hold;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_op = '0; b_in_amt = '0; b_out_ready = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef SHIFTER_STATUS_EN
        check("rst_zero", out_zero, 1'b0);
        check("rst_cout", out_cout, 1'b0);
`endif
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        send(2'b00, 16'h8A3C, 4'd8);  recv("rol8");
        send(2'b01, 16'h8A3C, 4'd5);  recv("sll5");
        send(2'b11, 16'h0001, 4'd1);  recv("srl1");
        send(2'b11, 16'h8A3C, 4'd0);  recv("srl0");
        send(2'b10, 16'h8A3C, 4'd15); recv("sra15");
        send(2'b00, 16'h8001, 4'd9);  recv("rol9");

        // Random requests
        for (int i = 0; i < 12; i++) begin
            send(2'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
            recv("rand");
        end

        // Backpressure then back-to-back issue
        send(2'b10, 16'h8A3C, 4'd12);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("bp_valid", out_valid, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("bp_data", out_data, e.data);
            check("bp_cycle", cyc, e.due);
`ifdef SHIFTER_STATUS_EN
            check("bp_cout", out_cout, e.cout);
`endif
        end
        hold = out_data;
        in_valid = 1'b1; in_op = 2'b01; in_data = 16'h8A3C; in_amt = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_data", out_data, hold);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        t = cyc;
        in_valid = 1'b0;
        push_exp(2'b01, 16'h8A3C, 5, t, 8);
        recv("b2b");

        // STEP=1 instance: one bit per cycle
        b_in_valid = 1'b1; b_in_op = 2'b01; b_in_data = 16'h0001; b_in_amt = 4'd15;
        #1;
        check("s1_in_ready", b_in_ready, 1'b1);
        @(posedge clk); #1;
        t = cyc;
        b_in_valid = 1'b0; b_in_data = 16'hFFFF;
        n = 0;
        while (!b_out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("s1_valid", b_out_valid, 1'b1);
        check("s1_data", b_out_data, 16'h8000);
        check("s1_cycle", cyc, t + 16);
`ifdef SHIFTER_STATUS_EN
        check("s1_cout", b_out_cout, 1'b0);
        check("s1_zero", b_out_zero, 1'b0);
`endif

        // Reset in the middle of a shift
        send(2'b10, 16'h8A3C, 4'd12);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_data", out_data, 16'h0);
        sb.delete();
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_ready", in_ready, 1'b1);
        check("postrst_valid", out_valid, 1'b0);
        send(2'b11, 16'h0001, 4'd1); recv("postrst");
        send(2'b10, 16'h8A3C, 4'd12); recv("postrst_sra");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
